// File: rtl/i2c_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_cmd_sequencer
//
// Purpose: buffers 32-bit I2C master control words in a small FIFO and issues
// them to the master one at a time. For each command it strobes wr_ctrl and
// waits for the master's busy flag (status[31]) to rise and then fall. It then
// returns the master's final status word on a valid/ready response port. If the
// master never goes busy, a timeout response is returned instead. A slave NACK
// can optionally park the sequencer in HALT until software flushes the queue.
//
// Ports:
//   clk, resetn      system clock, asynchronous active-low reset
//   cmd_valid/_data  command push (master ctrl_reg format)
//   cmd_ready        FIFO not full
//   flush            one-cycle pulse: empty FIFO, leave HALT
//   i2c_ctrl_data    control word to the master (held between issues)
//   i2c_wr_ctrl      one-cycle write strobe to the master
//   i2c_status       master status word (31 busy, 30/29 NACK, 26 init)
//   rsp_valid/_data  captured final status for the completed command
//   rsp_timeout      response produced because busy never rose
//   rsp_ready        response consumed
//   halted           sequencer parked after a NACK
//   level            FIFO occupancy
// ---------------------------------------------------------------------------
module i2c_cmd_sequencer #(
    parameter int DEPTH        = 8,
    parameter int BUSY_TIMEOUT = 255,
    parameter bit STOP_ON_NACK = 1'b1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     cmd_valid,
    input  logic [31:0]              cmd_data,
    output logic                     cmd_ready,
    input  logic                     flush,
    output logic [31:0]              i2c_ctrl_data,
    output logic                     i2c_wr_ctrl,
    input  logic [31:0]              i2c_status,
    output logic                     rsp_valid,
    output logic [31:0]              rsp_data,
    output logic                     rsp_timeout,
    input  logic                     rsp_ready,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_HALT      = 3'd4;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   level_q;
    logic          push, pop;

    assign cmd_ready = (level_q != (AW+1)'(DEPTH));
    assign push      = cmd_valid && cmd_ready && !flush;
    assign level     = level_q;

    // Storage carries no reset; emptiness is defined by the pointers/level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= cmd_data;
        end
    end

    // flush wins over both push and pop. A pop can only be requested in
    // ISSUE, which is entered only with a non-empty FIFO and no flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    logic [2:0]    state_q, state_d;
    logic          wr_ctrl_q, wr_ctrl_d;
    logic [31:0]   ctrl_data_q, ctrl_data_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_to_q, rsp_to_d;
    logic          nack;

    assign nack = i2c_status[30] | i2c_status[29];

    always_comb begin
        state_d     = state_q;
        wr_ctrl_d   = 1'b0;
        ctrl_data_d = ctrl_data_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_to_d    = rsp_to_q;
        pop         = 1'b0;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // Gating on rsp_valid guarantees a capture never overwrites
                // an unconsumed response. Skipping on flush keeps the pop in
                // ISSUE from hitting a FIFO emptied this cycle.
                if ((level_q != '0) && !i2c_status[31] && !i2c_status[26] &&
                    !rsp_valid_q && !flush) begin
                    state_d     = S_ISSUE;
                    wr_ctrl_d   = 1'b1;
                    ctrl_data_d = mem_q[rptr_q];
                end
            end
            S_ISSUE: begin
                pop     = 1'b1;
                cnt_d   = TW'(BUSY_TIMEOUT);
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (i2c_status[31]) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = i2c_status;
                    rsp_to_d    = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!i2c_status[31]) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = i2c_status;
                    rsp_to_d    = 1'b0;
                    state_d     = (STOP_ON_NACK && nack) ? S_HALT : S_IDLE;
                end
            end
            S_HALT: begin
                if (flush) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            wr_ctrl_q   <= 1'b0;
            ctrl_data_q <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ctrl_q   <= wr_ctrl_d;
            ctrl_data_q <= ctrl_data_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    assign i2c_wr_ctrl   = wr_ctrl_q;
    assign i2c_ctrl_data = ctrl_data_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_timeout   = rsp_to_q;
    assign halted        = (state_q == S_HALT);

endmodule

// File: doc/i2c_cmd_sequencer.md
Name: i2c_cmd_sequencer

Overview:
- Sits directly upstream of the I2C master. It buffers queued 32-bit I2C control words and issues them to the master one at a time.
- For each command it waits for the master's busy flag to rise and fall, then returns the master's final status word on a response handshake.
- It lets the CPU or an init ROM queue a full register-write/read sequence without polling the master per transaction.
- Optionally halts the queue when the slave NACKs.

Parameters:
- DEPTH, 8: command FIFO depth in entries. Power of 2, minimum 2.
- BUSY_TIMEOUT, 255: maximum cycles to wait for master busy (status[31]) to rise after a wr_ctrl pulse.
- STOP_ON_NACK, 1: when 1, an address or data NACK moves the sequencer to HALT.

Ports:
- clk  in  1  system clock; shared with the I2C master.
- resetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  push request.
- cmd_data  in  32  control word, in the master's ctrl_reg format (bit31 read, bit30 repeated start, 23:17 address, 15:8 subaddress, 7:0 data).
- cmd_ready  out  1  FIFO not full.
- flush  in  1  one-cycle pulse: empty the FIFO and clear HALT.
- i2c_ctrl_data  out  32  drives the master's ctrl_data.
- i2c_wr_ctrl  out  1  one-cycle write strobe to the master.
- i2c_status  in  32  master status word (31 busy, 30 address NACK, 29 data NACK, 28 read valid, 26 initializing, 7:0 read data).
- rsp_valid  out  1  response holding register full.
- rsp_data  out  32  captured master status for the completed command.
- rsp_timeout  out  1  qualifies rsp_data: master never went busy.
- rsp_ready  in  1  response consumed.
- halted  out  1  sequencer is in HALT.
- level  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values, applied asynchronously on resetn low:
  - state IDLE; FIFO empty; level 0; cmd_ready 1.
  - i2c_wr_ctrl 0; i2c_ctrl_data 0.
  - rsp_valid 0; rsp_data 0; rsp_timeout 0; halted 0; timeout counter 0.
- FIFO:
  - Push when cmd_valid && cmd_ready. cmd_ready = (level != DEPTH) and is independent of a same-cycle pop.
  - Pointers wrap modulo DEPTH.
  - A pop and a push in the same cycle leave level unchanged.
  - flush has priority over push: the FIFO empties and any same-cycle push is dropped.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HALT.
- IDLE:
  - Advances to ISSUE when level != 0, i2c_status[31] == 0, i2c_status[26] == 0 and rsp_valid == 0.
  - The sequencer never issues while the previous response is unconsumed.
- ISSUE (one cycle):
  - i2c_wr_ctrl = 1 and i2c_ctrl_data = FIFO head, both registered.
  - Pop the head, load the timeout counter with BUSY_TIMEOUT, go to WAIT_BUSY.
  - i2c_ctrl_data holds its value until the next ISSUE.
- WAIT_BUSY:
  - i2c_status[31] == 1: go to WAIT_DONE.
  - Else counter == 0: rsp_data = i2c_status, rsp_timeout = 1, rsp_valid = 1, go to IDLE.
  - Else decrement the counter.
  - Normal latency: the master goes busy in the cycle after the strobe.
- WAIT_DONE:
  - Waits for i2c_status[31] == 0, then captures i2c_status into rsp_data, rsp_timeout = 0, rsp_valid = 1.
  - If STOP_ON_NACK and (status[30] | status[29]): go to HALT. Otherwise go to IDLE.
- HALT:
  - halted = 1; no issuing. Pushes are still accepted while not full.
  - flush: empty the FIFO, go to IDLE, halted = 0.
- Response handshake:
  - rsp_valid clears in the cycle after rsp_valid && rsp_ready.
  - rsp_data and rsp_timeout are stable while rsp_valid = 1.
  - Capture never coincides with an unconsumed response, because IDLE gates on rsp_valid.
- flush in ISSUE, WAIT_BUSY or WAIT_DONE:
  - Empties the FIFO only. The in-flight transaction completes and produces its response.
- Overrun: the sequencer never strobes wr_ctrl while status[31] = 1, so master overrun (status[27]) never sets from this block.
- Reset mid-transaction: all state clears immediately. The master shares the reset and also returns to its start-up sequence.

Test Plan:
- Master model busy from reset with status[26] = 1 for 300 cycles; push one word 0x00_5A_10_33 -> no wr_ctrl before status[26] clears. Then exactly one wr_ctrl pulse with i2c_ctrl_data = 0x005A1033; rsp_data = final status, bit28 = 0; rsp_valid = 1.
- Push DEPTH+1 words while the model holds busy -> cmd_ready drops after 8 pushes and level = 8. The commands are then issued strictly in push order, one per busy-fall, with rsp_ready held 1.
- Read command 0x80_5A_20_00; model returns status 0x1000_00C3 -> rsp_data = 0x100000C3; the next command waits while rsp_ready = 0 and issues in the cycle after rsp_ready.
- Model sets status[30] = 1 on command 1 of 3, STOP_ON_NACK = 1 -> halted = 1, level = 2, no further wr_ctrl. Pulse flush -> level = 0, halted = 0.
- Model never raises busy -> after BUSY_TIMEOUT+1 cycles in WAIT_BUSY: rsp_valid = 1, rsp_timeout = 1; sequencer returns to IDLE.
- Assert resetn low during WAIT_DONE with 3 words queued -> level = 0, rsp_valid = 0, i2c_wr_ctrl = 0 asynchronously. Push and flush in the same cycle -> level stays 0.
